// File: rtl/lifo_reader.sv
// -----------------------------------------------------------------------------
// lifo_reader
//
// Drains a burst of words from a LIFO and presents them as a valid/ready
// stream, most recently stored word first. A burst starts from IDLE on
// start_i. The burst length is len_i clipped to the current LIFO level, or the
// whole LIFO level when len_i is zero. The length is latched at start, so later
// LIFO writes or len_i changes do not affect a running burst.
//
// A two-entry buffer absorbs the one-cycle LIFO read latency. While the buffer
// is empty, the word returned by an in-flight pop is forwarded directly from
// q_i. This keeps a continuous pop stream at one word per cycle when ready_i is
// held high. Pop requests depend only on registered state and empty_i.
//
// Ports
//   clk_i    : clock, all logic on the rising edge
//   arstn_i  : asynchronous active-low reset
//   start_i  : burst request, sampled only in IDLE
//   len_i    : requested word count, 0 = all stored words
//   rdreq_o  : pop request to the LIFO
//   q_i      : LIFO read data, valid the cycle after an accepted pop
//   empty_i  : LIFO empty flag
//   usedw_i  : LIFO fill level
//   data_o   : stream data
//   valid_o  : stream valid
//   ready_i  : stream ready, a word moves when valid_o && ready_i
//   last_o   : final word of the burst, qualified by valid_o
//   busy_o   : high whenever the FSM is not in IDLE
//   done_o   : one-cycle pulse when the burst has completed
// -----------------------------------------------------------------------------
module lifo_reader #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              start_i,
  input  logic [AWIDTH:0]   len_i,
  output logic              rdreq_o,
  input  logic [DWIDTH-1:0] q_i,
  input  logic              empty_i,
  input  logic [AWIDTH:0]   usedw_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [AWIDTH:0] ONE = 1;

  state_t              state;
  state_t              state_next;
  logic [AWIDTH:0]     eff_len;     // burst length latched at start
  logic [AWIDTH:0]     pops_left;   // pops still to be issued
  logic [AWIDTH:0]     words_left;  // words still to be transferred
  logic                in_flight;   // a pop was issued last cycle, q_i is valid now
  logic [1:0]          occupancy;   // words held in the buffer
  logic [1:0]          credits;     // buffered plus in-flight words
  logic                wr_ptr;
  logic                rd_ptr;
  logic [DWIDTH-1:0]   buf_mem [2];
  logic                xfer;

  // Effective length: all stored words on len_i == 0, otherwise min(len, level).
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    eff_len = len_i;
    if (len_i == '0 || len_i > usedw_i) begin
      eff_len = usedw_i;
    end
  end

  // A new pop is issued only if the buffer can still hold every word already
  // returned or in flight. ready_i does not take part, so no stream handshake
  // path reaches the LIFO.
  assign credits = occupancy + {1'b0, in_flight};
  assign rdreq_o = (state == POP) && !empty_i && (pops_left != '0) && (credits < 2'd2);

  // With an empty buffer the head of the stream is the word arriving on q_i.
  // That word is also written into buf_mem[wr_ptr], which equals rd_ptr then.
  // A stall therefore keeps presenting the same word, now from the buffer.
  assign valid_o = (occupancy != 2'd0) || in_flight;
  assign data_o  = (occupancy == 2'd0 && in_flight) ? q_i : buf_mem[rd_ptr];
  assign xfer    = valid_o && ready_i;
  assign last_o  = valid_o && (words_left == ONE);
  assign busy_o  = (state != IDLE);
  assign done_o  = (state == FLUSH) && (words_left == '0) && !in_flight && (occupancy == 2'd0);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_next = (eff_len == '0) ? FLUSH : POP;
        end
      end
      POP: begin
        if (pops_left == '0 || (rdreq_o && pops_left == ONE)) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (done_o) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      pops_left  <= '0;
      words_left <= '0;
      in_flight  <= 1'b0;
    end else begin
      // An in-flight pop is forgotten on reset, so its word is never shown.
      in_flight <= rdreq_o;
      if (state == IDLE && start_i) begin
        pops_left  <= eff_len;
        words_left <= eff_len;
      end else begin
        if (rdreq_o) begin
          pops_left <= pops_left - ONE;
        end
        if (xfer) begin
          words_left <= words_left - ONE;
        end
      end
    end
  end

  // Every returned word is captured one cycle after its pop, whatever the
  // handshake. A word taken straight from q_i is dropped again by advancing
  // rd_ptr, so occupancy is unchanged.
  // NOTE: the two buffer entries are reset because data_o must read 0 during
  // and after reset; larger memories would normally be left unreset.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      occupancy  <= 2'd0;
    end else begin
      if (in_flight) begin
        buf_mem[wr_ptr] <= q_i;
        wr_ptr          <= ~wr_ptr;
      end
      if (xfer) begin
        rd_ptr <= ~rd_ptr;
      end
      occupancy <= occupancy + {1'b0, in_flight} - {1'b0, xfer};
    end
  end

endmodule

// File: tb/tb_lifo_reader.sv
// -----------------------------------------------------------------------------
// tb_lifo_reader
//
// Bench for lifo_reader. A behavioural LIFO is driven by the DUT's rdreq_o.
// It is filled with BASE + index, so the k-th word of a burst is expected to be
// BASE + (top - k). A table of burst scenarios is applied in a loop. Separate
// sequences cover start while busy, LIFO writes during a burst, and reset in
// the middle of a burst.
// -----------------------------------------------------------------------------
module tb_lifo_reader;

  localparam int DW   = 16;
  localparam int AW   = 8;
  localparam int BASE = 16'h4000;

  logic          clk_i = 1'b0;
  logic          arstn_i;
  logic          start_i;
  logic [AW:0]   len_i;
  logic          rdreq_o;
  logic [DW-1:0] q_i = '0;
  logic          empty_i;
  logic [AW:0]   usedw_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i = 1'b1;
  logic          last_o;
  logic          busy_o;
  logic          done_o;

  lifo_reader #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .start_i (start_i),
    .len_i   (len_i),
    .rdreq_o (rdreq_o),
    .q_i     (q_i),
    .empty_i (empty_i),
    .usedw_i (usedw_i),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .last_o  (last_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural LIFO: registered read data, pop before push in the same cycle.
  logic [DW-1:0] mem [0:511];
  int            lifo_sp = 0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          lifo_clr = 1'b0;
  logic          pop_ok;

  assign pop_ok  = rdreq_o && (lifo_sp != 0);
  assign empty_i = (lifo_sp == 0);
  assign usedw_i = lifo_sp[AW:0];

  always @(posedge clk_i) begin
    if (lifo_clr) begin
      lifo_sp <= 0;
    end else begin
      if (pop_ok) q_i <= mem[lifo_sp-1];
      if (wr_en) mem[pop_ok ? lifo_sp-1 : lifo_sp] <= wr_data;
      lifo_sp <= lifo_sp - (pop_ok ? 1 : 0) + (wr_en ? 1 : 0);
    end
  end

  // Random or constant ready, changed just after each rising edge.
  bit rnd_ready = 1'b0;
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // Stream monitor, sampled on the falling edge.
  int   cyc = 0;
  int   pops, xfers, n_last, last_pos, done_cnt;
  int   stall_err, rdreq_empty_err, max_out;
  int   start_cyc, first_valid_cyc, last_xfer_cyc;
  bit   prev_stall;
  logic [DW-1:0] prev_data;
  logic prev_last;
  int   got_q[$];

  initial begin
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!arstn_i) begin
        prev_stall = 1'b0;
      end else begin
        if (rdreq_o && empty_i) rdreq_empty_err++;
        if (pops - xfers > max_out) max_out = pops - xfers;
        if (prev_stall && (!valid_o || data_o !== prev_data || last_o !== prev_last)) stall_err++;
        prev_stall = valid_o && !ready_i;
        prev_data  = data_o;
        prev_last  = last_o;
        if (start_i && !busy_o && start_cyc < 0) start_cyc = cyc;
        if (valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (rdreq_o && !empty_i) pops++;
        if (valid_o && ready_i) begin
          got_q.push_back(int'(data_o));
          xfers++;
          last_xfer_cyc = cyc;
          if (last_o) begin
            n_last++;
            last_pos = xfers;
          end
        end
        if (done_o) done_cnt++;
      end
    end
  end

  task automatic clear_stats();
    pops = 0; xfers = 0; n_last = 0; last_pos = 0; done_cnt = 0;
    stall_err = 0; rdreq_empty_err = 0; max_out = 0;
    start_cyc = -1; first_valid_cyc = -1; last_xfer_cyc = -1;
    prev_stall = 1'b0;
    got_q.delete();
  endtask

  task automatic fill_lifo(int n);
    @(posedge clk_i); #1;
    lifo_clr = 1'b1;
    @(posedge clk_i); #1;
    lifo_clr = 1'b0;
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = 16'(BASE + i);
      @(posedge clk_i); #1;
    end
    wr_en = 1'b0;
  endtask

  task automatic launch(int len);
    @(posedge clk_i); #1;
    start_i = 1'b1;
    len_i   = 9'(len);
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(string tag, int max_cyc);
    int n = 0;
    while (done_cnt == 0 && n < max_cyc) begin
      @(negedge clk_i); #1;
      n++;
    end
    check({tag, "/done_seen"}, int'(done_cnt != 0), 1);
    repeat (3) @(negedge clk_i);
    #1;
  endtask

  task automatic check_burst(string tag, int exp_words, int exp_usedw);
    check({tag, "/words"}, got_q.size(), exp_words);
    check({tag, "/last_count"}, n_last, (exp_words != 0) ? 1 : 0);
    check({tag, "/last_pos"}, last_pos, exp_words);
    check({tag, "/done_pulses"}, done_cnt, 1);
    check({tag, "/busy_after"}, int'(busy_o), 0);
    check({tag, "/pops"}, pops, exp_words);
    check({tag, "/usedw_after"}, int'(usedw_i), exp_usedw);
    check({tag, "/stall_unstable"}, stall_err, 0);
    check({tag, "/rdreq_while_empty"}, rdreq_empty_err, 0);
    check({tag, "/over_buffered"}, int'(max_out > 2), 0);
  endtask

  task automatic check_words(string tag, int top);
    foreach (got_q[k]) begin
      check($sformatf("%s/word%0d", tag, k), got_q[k], BASE + top - k);
    end
  endtask

  task automatic check_timing(string tag, int len);
    check({tag, "/first_valid_latency"}, first_valid_cyc - start_cyc, 2);
    check({tag, "/back_to_back"}, last_xfer_cyc - first_valid_cyc, len - 1);
  endtask

  typedef struct {
    int fill;
    int len;
    bit rnd;
    int exp_words;
    int exp_usedw;
    bit timing;
  } vec_t;

  vec_t  vecs[6];
  string tag;
  int    n;
  int    sp_at;

  initial begin
    vecs[0] = '{10,  4, 1'b0,   4, 6, 1'b1};  // partial burst, newest first
    vecs[1] = '{5,   0, 1'b0,   5, 0, 1'b1};  // len 0 drains everything
    vecs[2] = '{0,   8, 1'b0,   0, 0, 1'b0};  // empty lifo: no pops, done only
    vecs[3] = '{256, 0, 1'b1, 256, 0, 1'b0};  // full lifo, random backpressure
    vecs[4] = '{3,   7, 1'b0,   3, 3 - 3, 1'b1};  // len clipped to level
    vecs[5] = '{8,   1, 1'b1,   1, 7, 1'b0};  // single word burst

    arstn_i = 1'b0;
    start_i = 1'b0;
    len_i   = '0;
    clear_stats();

    // Reset state
    repeat (3) @(negedge clk_i);
    #1;
    check("reset/rdreq", int'(rdreq_o), 0);
    check("reset/valid", int'(valid_o), 0);
    check("reset/last",  int'(last_o), 0);
    check("reset/busy",  int'(busy_o), 0);
    check("reset/done",  int'(done_o), 0);
    check("reset/data",  int'(data_o), 0);
    arstn_i = 1'b1;

    // Table-driven bursts
    for (int i = 0; i < 6; i++) begin
      tag = $sformatf("vec%0d", i);
      rnd_ready = vecs[i].rnd;
      fill_lifo(vecs[i].fill);
      clear_stats();
      launch(vecs[i].len);
      wait_done(tag, 4000);
      check_burst(tag, vecs[i].exp_words, vecs[i].exp_usedw);
      check_words(tag, vecs[i].fill - 1);
      if (vecs[i].timing) check_timing(tag, vecs[i].exp_words);
    end
    rnd_ready = 1'b0;

    // A second start with a different length while busy is ignored.
    fill_lifo(10);
    clear_stats();
    launch(2);
    start_i = 1'b1;
    len_i   = 9'd9;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_done("busy", 200);
    check_burst("busy", 2, 8);
    check_words("busy", 9);

    // LIFO writes during a len 0 burst of 6 do not change the length.
    fill_lifo(6);
    clear_stats();
    launch(0);
    for (int i = 0; i < 3; i++) begin
      wr_en   = 1'b1;
      wr_data = 16'(16'hE000 + i);
      @(posedge clk_i); #1;
    end
    wr_en = 1'b0;
    wait_done("wr", 200);
    check_burst("wr", 6, 3);

    // Reset after 7 transfers of a 20-word burst, then restart with len 3.
    fill_lifo(30);
    clear_stats();
    launch(20);
    n = 0;
    while (xfers < 7 && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    check("rst/xfers_before_reset", xfers, 7);
    arstn_i = 1'b0;
    #1;
    check("rst/rdreq", int'(rdreq_o), 0);
    check("rst/valid", int'(valid_o), 0);
    check("rst/last",  int'(last_o), 0);
    check("rst/busy",  int'(busy_o), 0);
    check("rst/done",  int'(done_o), 0);
    check("rst/data",  int'(data_o), 0);
    start_i = 1'b1;
    len_i   = 9'd3;
    @(negedge clk_i); #1;
    check("rst/valid_held", int'(valid_o), 0);
    clear_stats();
    arstn_i   = 1'b1;
    start_cyc = cyc;
    sp_at     = lifo_sp;
    // 8 pops were issued by then: the 7 transferred words plus one in flight.
    check("rst/lifo_level", sp_at, 22);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("rst/start_accepted", int'(busy_o), 1);
    wait_done("rst", 200);
    check_burst("rst", 3, 19);
    check_words("rst", 21);
    check_timing("rst", 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
